mem_port_arbiter: RTL

//  Shares the single unified memory port between three requesters.
//  - Frontend instruction fetch (IF): read-only.
//  - Load/store data path (DM): read/write with byte enables.
//  - Debug program loader (DBG): write-only.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_prio_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_DBG} owner_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

  // Wide enough for DATA_W up to 512; users slice the low DATA_W/8 bits.
  localparam int                  BE_MAX_W = 64;
  localparam logic [BE_MAX_W-1:0] BE_ALL   = '1;

  localparam int REQ_IF  = 0;
  localparam int REQ_DM  = 1;
  localparam int REQ_DBG = 2;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational fixed-priority picker: DBG > DM > IF, with IF promoted above DM
// when the starve flag is set. Also intended for the cache refill port.
module arb_prio_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] reqs,
  input  logic       starve,
  output owner_t     winner
);

  always_comb begin
    winner = OWN_NONE;
    if (reqs[REQ_DBG]) begin
      winner = OWN_DBG;
    end else if (starve && reqs[REQ_IF]) begin
      winner = OWN_IF;
    end else if (reqs[REQ_DM]) begin
      winner = OWN_DM;
    end else if (reqs[REQ_IF]) begin
      winner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (IF / DM / DBG) onto one memory port, one access in flight.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
//
// state | meaning
// IDLE  | no access in flight; arbitration point
// ISSUE | mem_req held with stable command until mem_gnt
// WAIT  | accepted, waiting for mem_rvalid; re-arbitrates on that cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  input  logic                dbg_req,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_wdata,
  output logic                dbg_gnt,
  output logic                dbg_rvalid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_if_stall,
  output logic [31:0]         perf_dm_stall,
  output logic [31:0]         perf_xfers
`endif
);

  localparam int              BE_W    = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_FULL = BE_ALL[BE_W-1:0];

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  owner_t              winner;
  logic [3:0]          starve_q, starve_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                arb_open;
  logic                rsp;

  assign rsp      = (state_q == WAIT) && mem_rvalid;
  assign arb_open = (state_q == IDLE) || rsp;

  arb_prio_pick u_pick (
    .reqs   ({dbg_req, dm_req, if_req}),
    .starve (starve_q >= 4'(STARVE_MAX)),
    .winner (winner)
  );

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (state_q == ISSUE && mem_gnt) begin
      mem_req_d = 1'b0;
      state_d   = WAIT;
    end

    if (arb_open) begin
      owner_d     = winner;
      state_d     = (winner == OWN_NONE) ? IDLE : ISSUE;
      mem_req_d   = (winner != OWN_NONE);
      mem_we_d    = 1'b0;
      mem_be_d    = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      case (winner)
        OWN_IF: begin
          mem_be_d   = BE_FULL;
          mem_addr_d = if_addr;
        end
        OWN_DM: begin
          mem_we_d    = dm_we;
          mem_be_d    = dm_we ? dm_be : BE_FULL;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end
        OWN_DBG: begin
          mem_we_d    = 1'b1;
          mem_be_d    = BE_FULL;
          mem_addr_d  = dbg_addr;
          mem_wdata_d = dbg_wdata;
        end
        default: ;
      endcase
      if (if_req && winner != OWN_IF && starve_q != 4'hF) begin
        starve_d = starve_q + 4'd1;
      end
    end

    if (!if_req || (arb_open && winner == OWN_IF)) begin
      starve_d = '0;
    end
  end

  // Grants are gated by reset so every output reads 0 while it is held.
  assign if_gnt  = !nrst && arb_open && (winner == OWN_IF);
  assign dm_gnt  = !nrst && arb_open && (winner == OWN_DM);
  assign dbg_gnt = !nrst && arb_open && (winner == OWN_DBG);

  assign if_rvalid  = rsp && (owner_q == OWN_IF);
  assign dm_rvalid  = rsp && (owner_q == OWN_DM);
  assign dbg_rvalid = rsp && (owner_q == OWN_DBG);
  assign if_rdata   = if_rvalid ? mem_rdata : '0;
  assign dm_rdata   = (dm_rvalid && !mem_we_q) ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

  // A completion in the same cycle as the accept would be dropped.
  a_no_gnt_with_rvalid: assert property (@(posedge clk) disable iff (nrst)
    !(state_q == ISSUE && mem_gnt && mem_rvalid));

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_stall_q, perf_dm_stall_q, perf_xfers_q;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      perf_if_stall_q <= '0;
      perf_dm_stall_q <= '0;
      perf_xfers_q    <= '0;
    end else begin
      if (if_req && !if_gnt) perf_if_stall_q <= perf_if_stall_q + 32'd1;
      if (dm_req && !dm_gnt) perf_dm_stall_q <= perf_dm_stall_q + 32'd1;
      if (rsp)               perf_xfers_q    <= perf_xfers_q + 32'd1;
    end
  end

  assign perf_if_stall = perf_if_stall_q;
  assign perf_dm_stall = perf_dm_stall_q;
  assign perf_xfers    = perf_xfers_q;
`endif

endmodule
